// File: rtl/add_sub_serial.sv
// add_sub_serial: multi-cycle adder/subtractor for the Y86 ALU path.
// Operands are processed CHUNK bits per cycle, LSB chunk first, through a
// ripple chain of CHUNK full-adder slices. The carry between chunks lives in
// carry_q. The block produces a WIDTH-bit result and the ZF/SF/OF flags.
//
// Handshake contract (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. The input side is ready only in IDLE.
// The output side holds out_valid, result and flags stable in DONE until
// out_ready is seen. Operands are captured at the accepting edge, so later
// changes on a/b/sub do not affect the operation in flight.
module add_sub_serial #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [1:0]       dbg_state_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LAST   = NCHUNK - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;        // already inverted when subtracting
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               zf_q;
  logic               sf_q;
  logic               of_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   sum_chunk;
  logic [CHUNK:0]     c;          // c[i] is the carry into slice i
  logic [WIDTH-1:0]   result_d;
  logic               carry_d;
  logic               last_chunk;

  // Select the operand chunk addressed by the chunk counter.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // Ripple chain of CHUNK full-adder slices seeded by the held carry.
  always_comb begin
    c[0]      = carry_q;
    sum_chunk = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c[i];
      c[i+1]       = (a_chunk[i] & b_chunk[i]) |
                     (a_chunk[i] & c[i])       |
                     (b_chunk[i] & c[i]);
    end
  end

  // Merge the freshly computed chunk into the result word.
  always_comb begin
    result_d = result_q;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        result_d[k*CHUNK +: CHUNK] = sum_chunk;
      end
    end
  end

  assign carry_d    = c[CHUNK];
  assign last_chunk = (cnt_q == CNT_W'(LAST));

  // Control FSM plus datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b ^ {WIDTH{sub}};
            carry_q    <= sub;            // the +1 of A + ~B + 1
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end

        S_RUN: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          if (last_chunk) begin
            // Slice CHUNK-1 of the last chunk is bit WIDTH-1 of the word.
            of_q        <= c[CHUNK-1] ^ c[CHUNK];
            zf_q        <= (result_d == '0);
            sf_q        <= result_d[WIDTH-1];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zf          = zf_q;
  assign sf          = sf_q;
  assign of          = of_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: one instance at CHUNK=8 and one at CHUNK=1,
// sharing clock, reset and operand buses but with separate handshakes.
module tb_add_sub_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic        sub;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, zf0, sf0, of0;
  logic [63:0] result0;
  logic [1:0]  dbg_state0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, zf1, sf1, of1;
  logic [63:0] result1;
  logic [1:0]  dbg_state1;

  int n_assert = 0;
  int n_fail   = 0;

  // expected {of, sf, zf, result}
  logic [66:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  add_sub_serial #(.WIDTH(64), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid0), .out_ready(out_ready0),
    .result(result0), .zf(zf0), .sf(sf0), .of(of0), .dbg_state_o(dbg_state0)
  );

  add_sub_serial #(.WIDTH(64), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .zf(zf1), .sf(sf1), .of(of1), .dbg_state_o(dbg_state1)
  );

  // ---------------- reference model ----------------
  function automatic logic [66:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic s);
    logic [63:0] r;
    logic        o;
    r = s ? (x - y) : (x + y);
    if (!s) o = (x[63] == y[63]) && (r[63] != x[63]);
    else    o = (x[63] != y[63]) && (r[63] != x[63]);
    return {o, r[63], (r == 64'd0), r};
  endfunction

  // ---------------- DUT observation helpers ----------------
  function automatic logic ov(input bit w);
    return w ? out_valid1 : out_valid0;
  endfunction
  function automatic logic rdy(input bit w);
    return w ? in_ready1 : in_ready0;
  endfunction
  function automatic logic [63:0] res(input bit w);
    return w ? result1 : result0;
  endfunction
  function automatic logic [2:0] flags(input bit w);
    return w ? {of1, sf1, zf1} : {of0, sf0, zf0};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input bit w, input string tag);
    check({tag, "_in_ready"},  64'(rdy(w)), 64'd1);
    check({tag, "_out_valid"}, 64'(ov(w)), 64'd0);
    check({tag, "_result"},    res(w), 64'd0);
    check({tag, "_flags"},     64'(flags(w)), 64'd0);
  endtask

  task automatic set_hs(input bit w, input logic iv, input logic ordy);
    if (w) begin in_valid1 = iv; out_ready1 = ordy; end
    else   begin in_valid0 = iv; out_ready0 = ordy; end
  endtask

  // ---------------- driver: one full operation ----------------
  // Called #1 after a rising edge with the selected DUT in IDLE.
  task automatic do_op(input bit w, input logic [63:0] ta, input logic [63:0] tb,
                       input logic ts, input int hold, input bit junk);
    int          n;
    int          lat;
    logic [66:0] e;
    logic [63:0] held;
    n = w ? 64 : 8;
    a = ta; b = tb; sub = ts;
    set_hs(w, 1'b1, (hold == 0));
    check("in_ready_at_accept", 64'(rdy(w)), 64'd1);
    exp_q.push_back(model(ta, tb, ts));
    @(posedge clk); #1;
    if (!junk) set_hs(w, 1'b0, (hold == 0));
    lat = 0;
    while (!ov(w) && lat < 200) begin
      if (junk) begin
        check("in_ready_during_run", 64'(rdy(w)), 64'd0);
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    set_hs(w, 1'b0, (hold == 0));
    check("latency", 64'(lat), 64'(n));
    check("out_valid", 64'(ov(w)), 64'd1);
    e = exp_q.pop_front();
    check("result", res(w), e[63:0]);
    check("zf", 64'(flags(w)) & 64'd1, 64'(e[64]));
    check("sf", (64'(flags(w)) >> 1) & 64'd1, 64'(e[65]));
    check("of", (64'(flags(w)) >> 2) & 64'd1, 64'(e[66]));
    held = res(w);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 64'(ov(w)), 64'd1);
      check("stall_result", res(w), held);
    end
    set_hs(w, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("out_valid_after_hs", 64'(ov(w)), 64'd0);
    check("in_ready_after_hs", 64'(rdy(w)), 64'd1);
  endtask

  task automatic rand_op(input bit w);
    logic [63:0] ra;
    logic [63:0] rb;
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    if ($urandom_range(0, 9) == 0) rb = ra;
    if ($urandom_range(0, 9) == 0) ra = {1'b1, 63'($urandom)};
    do_op(w, ra, rb, 1'($urandom), 0, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero(0, "reset_held_c8");
    check_idle_zero(1, "reset_held_c1");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_zero(0, "reset_rel_c8");

    // basic add and subtract cases
    do_op(0, 64'd5, 64'd3, 1'b0, 0, 0);
    do_op(0, 64'd3, 64'd3, 1'b1, 0, 0);
    do_op(0, 64'd0, 64'd1, 1'b1, 0, 0);

    // signed overflow boundaries
    do_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 0);
    do_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 0, 0);
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 0);

    // handshake stress: junk operands during RUN, then stalled output
    do_op(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 5, 1);
    do_op(0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 0, 0);

    for (int i = 0; i < 100; i++) rand_op(0);

    // reset in the middle of RUN after three chunks
    a = 64'hDEAD_BEEF_CAFE_F00D; b = 64'h0123_4567_89AB_CDEF; sub = 1'b0;
    set_hs(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_hs(0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero(0, "reset_mid_run");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 64'd10, 64'd20, 1'b0, 0, 0);

    // bit-serial instance: directed corners then random sweep
    do_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 0);
    do_op(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 2, 1);
    for (int i = 0; i < 1000; i++) rand_op(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
